// File: rtl/ins_fetch_unit_pkg.sv
// Shared CPU definitions: opcodes, condition codes and fetch-state encoding.
package cpu_defs;

  localparam logic [4:0]  OP_JMP   = 5'b11000;
  localparam logic [4:0]  OP_LD    = 5'b10100;
  localparam logic [4:0]  OP_ST    = 5'b10101;
  localparam logic [2:0]  COND_PFX = 3'b111;
  localparam logic [23:0] NOP      = 24'h0;

  typedef enum logic [1:0] {
    CC_Z  = 2'b00,
    CC_NZ = 2'b01,
    CC_C  = 2'b10,
    CC_NC = 2'b11
  } cond_code_e;

  localparam logic [1:0] ST_FETCH    = 2'b00;
  localparam logic [1:0] ST_LD_HOLD  = 2'b01;
  localparam logic [1:0] ST_REDIRECT = 2'b10;

endpackage

// File: rtl/ins_fetch_unit_branch_cond.sv
// Combinational jump-taken decision for the opcode currently held on ins.
module branch_cond
  import cpu_defs::*;
(
  input  logic [4:0] op_i,
  input  logic       zero_i,
  input  logic       carry_i,
  output logic       take_o
);

  logic cond_met;

  always_comb begin
    cond_met = 1'b0;
    case (op_i[1:0])
      CC_Z:    cond_met = zero_i;
      CC_NZ:   cond_met = ~zero_i;
      CC_C:    cond_met = carry_i;
      default: cond_met = ~carry_i;
    endcase
  end

  assign take_o = (op_i == OP_JMP) | ((op_i[4:2] == COND_PFX) & cond_met);

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: PC, registered instruction, jump redirect bubble and load hold.
module ins_fetch_unit
  import cpu_defs::*;
#(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_data,
  input  logic              zero_flag,
  input  logic              carry_flag,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              redirect
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic              redirect_q, redirect_d;
  logic [1:0]        state_q, state_d;
  logic [4:0]        op;
  logic              take;

  assign op = ins_q[INS_W-1:INS_W-5];

  branch_cond u_branch_cond (
    .op_i    (op),
    .zero_i  (zero_flag),
    .carry_i (carry_flag),
    .take_o  (take)
  );

  always_comb begin
    pc_d       = pc_q;
    ins_d      = ins_q;
    ins_pc_d   = ins_pc_q;
    redirect_d = redirect_q;
    state_d    = state_q;
    case (state_q)
      ST_FETCH: begin
        if (take) begin
          pc_d       = ins_q[ADDR_W:1];
          ins_d      = '0;
          ins_pc_d   = '0;
          redirect_d = 1'b1;
          state_d    = ST_REDIRECT;
        end else if (op == OP_LD) begin
          state_d = ST_LD_HOLD;
        end else begin
          ins_d    = imem_data;
          ins_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(1);
        end
      end
      // Second cycle of a load or the bubble after a jump: always issue the next word.
      ST_LD_HOLD, ST_REDIRECT: begin
        ins_d      = imem_data;
        ins_pc_d   = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
        redirect_d = 1'b0;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      ins_q      <= '0;
      ins_pc_q   <= '0;
      redirect_q <= 1'b0;
      state_q    <= ST_FETCH;
    end else begin
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      ins_pc_q   <= ins_pc_d;
      redirect_q <= redirect_d;
      state_q    <= state_d;
    end
  end

  assign imem_addr = pc_q;
  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;
  assign redirect  = redirect_q;

endmodule
